// File: rtl/sum_accum_core_if.sv
// Operand/result stream bundle for sum_accum_core: operand beat in, registered result out.
interface sum_accum_core_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sum_accum_core.sv
// Two-operand adder/accumulator with four per-beat modes, one registered output stage,
// sticky overflow flag and saturating accepted-beat counter.
module sum_accum_core #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  sum_accum_core_if.slave  bus,
  output logic             ovf,
  output logic [CNT_W-1:0] count
);
  generate
    if (ACC_W < WIDTH + 1) begin : g_bad_width
      $error("sum_accum_core: ACC_W must be at least WIDTH+1");
    end
  endgenerate

  localparam logic [1:0] M_ADD = 2'd0, M_ADD_SAT = 2'd1, M_ACC = 2'd2, M_ACC_SAT = 2'd3;

  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;
  logic [ACC_W-1:0] acc;

  logic             accept;
  logic [WIDTH:0]   s;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] res;
  logic [ACC_W-1:0] acc_nxt;
  logic             beat_ovf;
  logic             ovf_base;
  logic [CNT_W-1:0] cnt_base;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign accept        = bus.in_valid && bus.in_ready;

  // clear takes effect before a same-cycle beat, so the beat sees zeroed state
  assign acc_base = clear ? '0 : acc;
  assign ovf_base = clear ? 1'b0 : ovf;
  assign cnt_base = clear ? '0 : count;

  always_comb begin
    s        = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    acc_sum  = {1'b0, acc_base} + (ACC_W+1)'(s);
    res      = '0;
    beat_ovf = 1'b0;
    acc_nxt  = acc_base;
    case (bus.in_mode)
      M_ADD: res = ACC_W'(s);
      M_ADD_SAT: begin
        if (s[WIDTH]) begin
          res      = ACC_W'({WIDTH{1'b1}});
          beat_ovf = 1'b1;
        end else begin
          res = ACC_W'(s);
        end
      end
      M_ACC: begin
        res      = acc_sum[ACC_W-1:0];
        beat_ovf = acc_sum[ACC_W];
        acc_nxt  = acc_sum[ACC_W-1:0];
      end
      M_ACC_SAT: begin
        if (acc_sum[ACC_W]) begin
          res      = '1;
          beat_ovf = 1'b1;
        end else begin
          res = acc_sum[ACC_W-1:0];
        end
        acc_nxt = res;
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      acc         <= '0;
      ovf         <= 1'b0;
      count       <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res;
        acc         <= acc_nxt;
        ovf         <= ovf_base | beat_ovf;
        count       <= (&cnt_base) ? cnt_base : cnt_base + 1'b1;
      end else begin
        if (bus.out_ready) out_valid_q <= 1'b0;
        acc   <= acc_base;
        ovf   <= ovf_base;
        count <= cnt_base;
      end
    end
  end
endmodule

// File: tb/tb_sum_accum_core.sv
// Directed bench for sum_accum_core: vector table plus backpressure, counter-saturation and reset sequences.
module tb_sum_accum_core;
  localparam int WIDTH = 8, ACC_W = 12, CNT_W = 4;
  localparam logic [1:0] ADD = 2'd0, SAT = 2'd1, ACC = 2'd2, ACS = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             ovf;
  logic [CNT_W-1:0] count;

  sum_accum_core_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

  sum_accum_core #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus.slave),
    .ovf   (ovf),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int         a;
    int         b;
    logic       clr;
    int         exp_d;
    int         exp_o;
    int         exp_c;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void push(logic [1:0] m, int a, int b, logic c, int d, int o, int n);
    vec_t v;
    v.mode = m; v.a = a; v.b = b; v.clr = c; v.exp_d = d; v.exp_o = o; v.exp_c = n;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(logic [1:0] m, int a, int b, logic c);
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_a     = WIDTH'(a);
    bus.in_b     = WIDTH'(b);
    clear        = c;
  endtask

  initial begin
    // ADD / ADD_SAT basics, including unclamped boundaries
    push(ADD, 200, 100, 0, 300, 0, 1);
    push(SAT, 200, 100, 0, 255, 1, 2);
    push(ADD,   1,   1, 0,   2, 1, 3);
    push(ADD, 255, 255, 0, 510, 1, 4);
    // ACC_SAT: 8 beats to 4080, 9th clamps, then ACC 0+0 holds at 4095
    push(ACS, 255, 255, 1, 510, 0, 1);
    for (int k = 2; k <= 8; k++) push(ACS, 255, 255, 0, 510*k, 0, k);
    push(ACS, 255, 255, 0, 4095, 1, 9);
    push(ACC,   0,   0, 0, 4095, 1, 10);
    push(SAT, 100, 155, 0,  255, 1, 11);
    // ACC wrap: preload 4080 then +20 wraps to 4
    push(ACC, 255, 255, 1, 510, 0, 1);
    for (int k = 2; k <= 8; k++) push(ACC, 255, 255, 0, 510*k, 0, k);
    push(ACC,  10,  10, 0,    4, 1, 9);
    push(ACC, 248, 248, 0,  500, 1, 10);
    push(ACC, 250, 250, 0, 1000, 1, 11);
    // clear with simultaneous accept from acc=1000
    push(ACC,   3,   4, 1,    7, 0, 1);
    push(ADD,   5,   5, 0,   10, 0, 2);
    push(ACC,   1,   0, 0,    8, 0, 3);
    push(SAT, 100, 155, 0,  255, 0, 4);

    rst = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_mode = ADD; bus.out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data",  int'(bus.out_data), 0);
    chk("rst_ovf",       int'(ovf), 0);
    chk("rst_count",     int'(count), 0);
    chk("rst_in_ready",  int'(bus.in_ready), 1);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      beat(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].clr);
      tick();
      chk($sformatf("vec%0d_valid", i), int'(bus.out_valid), 1);
      chk($sformatf("vec%0d_data", i),  int'(bus.out_data), vecs[i].exp_d);
      chk($sformatf("vec%0d_ovf", i),   int'(ovf), vecs[i].exp_o);
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_c);
    end

    // clear alone; transfer with no accept drops out_valid
    bus.in_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("idle_valid", int'(bus.out_valid), 0);
    chk("clr_count",  int'(count), 0);
    chk("clr_ovf",    int'(ovf), 0);

    // backpressure: first beat held, later beats stream once released
    bus.out_ready = 1'b0;
    beat(ADD, 10, 1, 0);
    tick();
    chk("bp_valid", int'(bus.out_valid), 1);
    chk("bp_data",  int'(bus.out_data), 11);
    chk("bp_ready", int'(bus.in_ready), 0);
    beat(ADD, 20, 2, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_hold%0d_data", k),  int'(bus.out_data), 11);
      chk($sformatf("bp_hold%0d_ready", k), int'(bus.in_ready), 0);
      chk($sformatf("bp_hold%0d_count", k), int'(count), 1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(bus.in_ready), 1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk($sformatf("bp_stream%0d_data", k),  int'(bus.out_data), 11*k);
      chk($sformatf("bp_stream%0d_count", k), int'(count), k);
      beat(ADD, 10*(k+1), k+1, 0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", int'(bus.out_valid), 0);
    chk("bp_final_count", int'(count), 4);

    // counter saturation over 17 accepts
    for (int i = 0; i < 17; i++) begin
      beat(ADD, i, 0, (i == 0));
      tick();
      chk($sformatf("cnt_sat%0d", i), int'(count), (i + 1 > 15) ? 15 : i + 1);
    end
    clear = 1'b0;

    // reset while a result is stalled
    beat(SAT, 200, 100, 0);
    tick();
    bus.out_ready = 1'b0;
    beat(ACC, 5, 5, 0);
    tick();
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    chk("pre_rst_ovf",   int'(ovf), 1);
    bus.in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_ovf",   int'(ovf), 0);
    chk("mid_rst_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    beat(ACC, 0, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("mid_rst_acc", int'(bus.out_data), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
